sha256_msg_feeder: RTL

- Initiator for the SHA-256 compression core's word interface.
- Accepts a byte-oriented message as a stream of big-endian 32-bit words and applies FIPS 180-4 padding: 0x80 marker, zero fill and 64-bit bit-length.
- Drives the core's init / EN / 32-bit data inputs in the core's 68-slot-per-block timing, then captures the 256-bit digest and presents it with a valid pulse.
- Sits between the AXI-side message buffer and the hashing core inside the KEM hash path.

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_pad_word.sv | 33 +++
 rtl/sha256_msg_feeder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 message feeder shared types and constants.
// State encoding, core slot markers, padding marker, IV.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MSG,
    S_PAD,
    S_COMP,
    S_CAP
  } state_e;

  typedef struct packed {
    logic msg_done;
    logic mark_done;
    logic len_sent;
  } pad_flags_t;

  localparam logic [6:0] SLOT_LAST     = 7'd67;
  localparam logic [6:0] SLOT_MSG_LAST = 7'd15;
  localparam logic [6:0] SLOT_LEN_HI   = 7'd14;

  localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85,
    32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c,
    32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word byte mask with 0x80 marker insertion.
// data_i/last_i/nbytes_i in; word_o padded word, marked_o marker placed.
module sha256_pad_word (
  input  logic [31:0] data_i,
  input  logic        last_i,
  input  logic [1:0]  nbytes_i,
  output logic [31:0] word_o,
  output logic        marked_o
);

  always_comb begin
    word_o   = data_i;
    marked_o = 1'b0;
    if (last_i) begin
      unique case (nbytes_i)
        2'd1: begin
          word_o   = {data_i[31:24], 24'h80_0000};
          marked_o = 1'b1;
        end
        2'd2: begin
          word_o   = {data_i[31:16], 16'h8000};
          marked_o = 1'b1;
        end
        2'd3: begin
          word_o   = {data_i[31:8], 8'h80};
          marked_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 core initiator: pads a word stream and feeds 68-slot blocks.
// s_* message in; core_* core word port; digest/digest_valid; busy.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [1:0]   s_nbytes,
  output logic         core_init,
  output logic         core_en,
  output logic [31:0]  core_data,
  input  logic [255:0] core_hash,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  state_e           state_q, state_d;
  logic [6:0]       slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pad_flags_t       flg_q, flg_d;
  logic [255:0]     digest_q, digest_d;
  logic             dv_q, dv_d;

  logic        hs;
  logic        slot_wrap;
  logic [31:0] msg_word;
  logic        msg_marked;
  logic [2:0]  nb_add;
  logic [63:0] len_w;
  logic [31:0] pad_w;
  logic        emit_mark;
  logic        emit_hi;

  sha256_pad_word u_pad (
    .data_i   (s_data),
    .last_i   (s_last),
    .nbytes_i (s_nbytes),
    .word_o   (msg_word),
    .marked_o (msg_marked)
  );

  assign hs        = s_valid & s_ready;
  assign slot_wrap = (slot_q == SLOT_LAST);
  assign nb_add    = msg_marked ? {1'b0, s_nbytes} : 3'd4;
  assign len_w     = {{(61-CNT_W){1'b0}}, cnt_q, 3'b000};

  assign digest       = digest_q;
  assign digest_valid = dv_q;
  assign busy         = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (s_valid) state_d = S_INIT;
      S_INIT: state_d = S_MSG;
      S_MSG: begin
        if (hs) begin
          if (slot_q == SLOT_MSG_LAST) state_d = S_COMP;
          else if (s_last)             state_d = S_PAD;
        end
      end
      S_PAD: if (slot_q == SLOT_MSG_LAST) state_d = S_COMP;
      S_COMP: begin
        if (slot_wrap) begin
          if (!flg_q.msg_done)      state_d = S_MSG;
          else if (!flg_q.len_sent) state_d = S_PAD;
          else                      state_d = S_CAP;
        end
      end
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Length goes out only if the marker already sat at slot 13 or earlier;
  // otherwise slots 14/15 stay zero and a further block carries it.
  always_comb begin
    pad_w     = '0;
    emit_mark = 1'b0;
    emit_hi   = 1'b0;
    if (!flg_q.mark_done) begin
      pad_w     = PAD_MARKER;
      emit_mark = 1'b1;
    end else if (slot_q == SLOT_LEN_HI) begin
      pad_w   = len_w[63:32];
      emit_hi = 1'b1;
    end else if (slot_q == SLOT_MSG_LAST && flg_q.len_sent) begin
      pad_w = len_w[31:0];
    end
  end

  always_comb begin
    s_ready   = 1'b0;
    core_init = 1'b0;
    core_en   = 1'b0;
    core_data = '0;
    unique case (state_q)
      S_INIT: core_init = 1'b1;
      S_MSG: begin
        s_ready   = 1'b1;
        core_en   = s_valid;
        core_data = s_valid ? msg_word : '0;
      end
      S_PAD: begin
        core_en   = 1'b1;
        core_data = pad_w;
      end
      S_COMP:  core_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    flg_d    = flg_q;
    digest_d = digest_q;
    dv_d     = (state_q == S_CAP);
    if (core_en) begin
      slot_d = slot_wrap ? 7'd0 : slot_q + 7'd1;
    end
    unique case (state_q)
      S_INIT: begin
        slot_d = '0;
        cnt_d  = '0;
        flg_d  = '0;
      end
      S_MSG: begin
        if (hs) begin
          cnt_d           = cnt_q + CNT_W'(nb_add);
          flg_d.msg_done  = s_last;
          flg_d.mark_done = msg_marked;
        end
      end
      S_PAD: begin
        if (emit_mark) flg_d.mark_done = 1'b1;
        if (emit_hi)   flg_d.len_sent  = 1'b1;
      end
      S_CAP:   digest_d = core_hash;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      cnt_q    <= '0;
      flg_q    <= '0;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      flg_q    <= flg_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
    end
  end

endmodule
